// File: rtl/ml_qpi_rx.sv
// rtl/ml_qpi_rx.sv - quad-SPI DDR receive front end with byte FIFO
module ml_qpi_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ml_csb,
    input  logic       ml_clk,
    input  logic [3:0] ml_io,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_first,
    output logic       xfer_end,
    output logic       busy,
    output logic       overflow,
    input  logic       ovf_clear
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // synchronizer stages hold coherent snapshots {csb, clk, io[3:0]}
    logic [5:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    // prime_q[2] marks that s3 holds a real pin sample rather than a reset value
    logic [2:0]    prime_q, prime_d;
    logic          blocked_q, blocked_d;
    logic          act_q, act_d;
    logic          half_q, half_d;
    logic          first_pend_q, first_pend_d;
    logic          overflow_q, overflow_d;
    logic [3:0]    hi_nib_q, hi_nib_d;
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [8:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic       s2_csb, s2_clk, s3_csb, s3_clk;
    logic [3:0] s3_io;
    logic       act, rise, fall, desel, complete, full, push, pop;

    assign s2_csb = s2_q[5];
    assign s2_clk = s2_q[4];
    assign s3_csb = s3_q[5];
    assign s3_clk = s3_q[4];
    assign s3_io  = s3_q[3:0];

    // after reset, edges stay blocked until csb has been observed high on the pins
    assign act      = !s2_csb && !s3_csb && !blocked_q;
    assign rise     = s2_clk && !s3_clk && act;
    assign fall     = !s2_clk && s3_clk && act;
    assign desel    = s2_csb && !s3_csb;
    assign complete = fall && half_q;
    assign full     = (count_q == FULL_CNT);
    assign pop      = out_valid && out_ready;
    assign push     = complete && (!full || pop);

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q][7:0];
    assign out_first = mem_q[rd_ptr_q][8];
    assign xfer_end  = desel;
    assign busy      = !s2_csb;
    assign overflow  = overflow_q;

    // next-state logic: edge detection, nibble assembly, first tagging, FIFO
    always_comb begin
        s1_d         = {ml_csb, ml_clk, ml_io};
        s2_d         = s1_q;
        s3_d         = s2_q;
        prime_d      = {prime_q[1:0], 1'b1};
        blocked_d    = blocked_q && !(prime_q[2] && s3_csb);
        act_d        = act;
        half_d       = half_q;
        hi_nib_d     = hi_nib_q;
        first_pend_d = first_pend_q;
        overflow_d   = overflow_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (rise) begin
            hi_nib_d = s3_io;
            half_d   = 1'b1;
        end
        if (act && !act_q) begin
            first_pend_d = 1'b1;
        end
        if (complete) begin
            half_d       = 1'b0;
            first_pend_d = 1'b0;
        end
        if (desel) begin
            half_d       = 1'b0;
            first_pend_d = 1'b0;
        end

        if (push) begin
            mem_d[wr_ptr_q] = {first_pend_q, hi_nib_q, s3_io};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (ovf_clear) begin
            overflow_d = 1'b0;
        end
        if (complete && !push) begin
            overflow_d = 1'b1;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q         <= 6'b110000;
            s2_q         <= 6'b110000;
            s3_q         <= 6'b110000;
            prime_q      <= '0;
            blocked_q    <= 1'b1;
            act_q        <= 1'b0;
            half_q       <= 1'b0;
            hi_nib_q     <= '0;
            first_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            prime_q      <= prime_d;
            blocked_q    <= blocked_d;
            act_q        <= act_d;
            half_q       <= half_d;
            hi_nib_q     <= hi_nib_d;
            first_pend_q <= first_pend_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_ml_qpi_rx.sv
// tb/tb_ml_qpi_rx.sv - scoreboard bench for ml_qpi_rx
module tb_ml_qpi_rx;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ml_csb;
    logic       ml_clk;
    logic [3:0] ml_io;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_first;
    logic       xfer_end;
    logic       busy;
    logic       overflow;
    logic       ovf_clear;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int xfers  = 0;
    logic [8:0] sb[$];

    ml_qpi_rx #(.FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ml_csb    (ml_csb),
        .ml_clk    (ml_clk),
        .ml_io     (ml_io),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .xfer_end  (xfer_end),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    always #5 clock = ~clock;

    // scoreboard: pop and compare every accepted beat, count xfer_end pulses
    always @(negedge clock) begin
        if (xfer_end) xfers++;
        if (out_valid && out_ready) begin
            logic [8:0] exp;
            beats++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got data=%h first=%b, required no beat", out_data, out_first);
            end else begin
                exp = sb.pop_front();
                if ({out_first, out_data} !== exp) begin
                    errors++;
                    $display("FAIL beat: got data=%h first=%b, required data=%h first=%b",
                             out_data, out_first, exp[7:0], exp[8]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        ml_io  = b[7:4];
        ml_clk = 1'b0;
        #17;
        ml_io  = b[3:0];
        ml_clk = 1'b1;
        #17;
    endtask

    task automatic start_xact();
        ml_csb = 1'b0;
        #34;
    endtask

    task automatic end_xact();
        ml_clk = 1'b0;
        #17;
        ml_csb = 1'b1;
        #17;
        ml_clk = 1'b1;
        #34;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clock);
        #1;
        out_ready = v;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_counts(input string name, input int b0, input int x0,
                                input int exp_b, input int exp_x);
        checks++;
        if (beats - b0 !== exp_b) begin
            errors++;
            $display("FAIL %s_beats: got %0d, required %0d", name, beats - b0, exp_b);
        end
        checks++;
        if (xfers - x0 !== exp_x) begin
            errors++;
            $display("FAIL %s_xfer_end: got %0d, required %0d", name, xfers - x0, exp_x);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({out_valid, out_data, out_first, xfer_end, busy, overflow} !== 13'd0) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h first=%b xfer_end=%b busy=%b ovf=%b, required all 0",
                     name, out_valid, out_data, out_first, xfer_end, busy, overflow);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        ml_csb    = 1'b1;
        ml_clk    = 1'b1;
        ml_io     = 4'h0;
        out_ready = 1'b1;
        ovf_clear = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset_state");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_single();
        int b0 = beats;
        int x0 = xfers;
        sb.push_back({1'b1, 8'hA5});
        start_xact();
        send_byte(8'hA5);
        end_xact();
        wait_drain("single");
        check_counts("single", b0, x0, 1, 1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        int x0 = xfers;
        for (int i = 0; i < 32; i++) begin
            sb.push_back({1'b1, 8'(i)});
            start_xact();
            send_byte(8'(i));
            end_xact();
        end
        wait_drain("b2b");
        check_counts("b2b", b0, x0, 32, 32);
    endtask

    task automatic test_multi_byte();
        int b0 = beats;
        int x0 = xfers;
        logic [7:0] bytes [3] = '{8'h12, 8'h34, 8'h56};
        start_xact();
        for (int i = 0; i < 3; i++) begin
            sb.push_back({(i == 0), bytes[i]});
            send_byte(bytes[i]);
        end
        end_xact();
        wait_drain("multi");
        check_counts("multi", b0, x0, 3, 1);
    endtask

    task automatic test_overflow();
        int b0 = beats;
        set_ready(1'b0);
        start_xact();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) sb.push_back({(i == 1), 8'(i)});
            send_byte(8'(i));
        end
        end_xact();
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b, required 1", overflow);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_first !== 1'b1) begin
            errors++;
            $display("FAIL ovf_head: got valid=%b data=%h first=%b, required 1/01/1",
                     out_valid, out_data, out_first);
        end
        set_ready(1'b1);
        wait_drain("ovf");
        check_counts("ovf", b0, xfers, 4, 0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", overflow);
        end
        @(posedge clock);
        #1;
        ovf_clear = 1'b1;
        @(posedge clock);
        #1;
        ovf_clear = 1'b0;
        @(negedge clock);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_half_byte();
        int b0 = beats;
        int x0 = xfers;
        start_xact();
        ml_io  = 4'hC;
        ml_clk = 1'b0;
        #17;
        ml_clk = 1'b1;
        #17;
        ml_csb = 1'b1;
        #51;
        repeat (3) @(posedge clock);
        check_counts("half", b0, x0, 0, 1);
        b0 = beats;
        sb.push_back({1'b1, 8'h3C});
        start_xact();
        send_byte(8'h3C);
        end_xact();
        wait_drain("after_half");
        check_counts("after_half", b0, xfers, 1, 0);
    endtask

    task automatic test_reset_mid();
        int b0;
        start_xact();
        ml_io  = 4'h9;
        ml_clk = 1'b0;
        #17;
        ml_clk = 1'b1;
        #17;
        @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("mid_reset_state");
        @(posedge clock);
        #1;
        resetn = 1'b1;
        b0 = beats;
        // byte finished while csb stayed low through reset must be dropped
        send_byte(8'h77);
        end_xact();
        repeat (6) @(posedge clock);
        check_counts("post_reset_blocked", b0, xfers, 0, xfers - xfers);
        b0 = beats;
        sb.push_back({1'b1, 8'hF0});
        start_xact();
        send_byte(8'hF0);
        end_xact();
        wait_drain("post_reset");
        check_counts("post_reset", b0, xfers, 1, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_multi_byte();
        test_overflow();
        test_half_byte();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
